// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM core pipeline stage registers:
// the stage occupancy enum and default ctrl/data widths per stage.
package arm_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

   localparam int ID_EX_CTRL_W   = 8;
   localparam int ID_EX_DATA_W   = 128;
   localparam int EX_MEM_CTRL_W  = 4;
   localparam int EX_MEM_DATA_W  = 72;
   localparam int MEM_WB_CTRL_W  = 2;
   localparam int MEM_WB_DATA_W  = 68;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flushable control field,
// optional data clear and a saturating stall counter. PIPE_STAGE_REG_SKID_EN adds a 2-entry skid buffer.
module pipe_stage_reg
   import arm_pipe_pkg::*;
#(
   parameter int CTRL_W     = ID_EX_CTRL_W,
   parameter int DATA_W     = ID_EX_DATA_W,
   parameter bit CLEAR_DATA = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   pipe_state_e       state_r, state_s;
   logic [CTRL_W-1:0] ctrl_r, ctrl_s;
   logic [DATA_W-1:0] data_r, data_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              in_xfer_s, out_xfer_s;
`ifdef PIPE_STAGE_REG_SKID_EN
   logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_s;
   logic [DATA_W-1:0] skid_data_r, skid_data_s;

   // Registered ready: no path from out_ready back to in_ready.
   assign in_ready = (state_r != ST_TWO);
`else
   assign in_ready = (state_r == ST_EMPTY) || out_ready;
`endif

   assign out_valid  = (state_r != ST_EMPTY);
   assign out_ctrl   = ctrl_r;
   assign out_data   = data_r;
   assign stall_cnt  = cnt_r;
   assign in_xfer_s  = in_valid && in_ready && !flush;
   assign out_xfer_s = out_valid && out_ready;

   // Next-state and payload routing; ctrl is zeroed whenever the stage goes empty.
   always_comb begin
      state_s = state_r;
      ctrl_s  = ctrl_r;
      data_s  = data_r;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_ctrl_s = skid_ctrl_r;
      skid_data_s = skid_data_r;
`endif
      if (flush) begin
         state_s = ST_EMPTY;
         ctrl_s  = {CTRL_W{1'b0}};
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_ctrl_s = {CTRL_W{1'b0}};
`endif
         if (CLEAR_DATA) begin
            data_s = {DATA_W{1'b0}};
`ifdef PIPE_STAGE_REG_SKID_EN
            skid_data_s = {DATA_W{1'b0}};
`endif
         end else begin
            data_s = data_r;
         end
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_xfer_s) begin
                  state_s = ST_ONE;
                  ctrl_s  = in_ctrl;
                  data_s  = in_data;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            ST_ONE: begin
               if (in_xfer_s && out_xfer_s) begin
                  ctrl_s = in_ctrl;
                  data_s = in_data;
               end else if (in_xfer_s) begin
                  state_s     = ST_TWO;
                  skid_ctrl_s = in_ctrl;
                  skid_data_s = in_data;
               end else if (out_xfer_s) begin
                  state_s = ST_EMPTY;
                  ctrl_s  = {CTRL_W{1'b0}};
               end else begin
                  state_s = ST_ONE;
               end
            end
            ST_TWO: begin
               if (out_xfer_s) begin
                  state_s     = ST_ONE;
                  ctrl_s      = skid_ctrl_r;
                  data_s      = skid_data_r;
                  skid_ctrl_s = {CTRL_W{1'b0}};
               end else begin
                  state_s = ST_TWO;
               end
            end
`else
            ST_ONE: begin
               if (in_xfer_s) begin
                  ctrl_s = in_ctrl;
                  data_s = in_data;
               end else if (out_xfer_s) begin
                  state_s = ST_EMPTY;
                  ctrl_s  = {CTRL_W{1'b0}};
               end else begin
                  state_s = ST_ONE;
               end
            end
`endif
            default: begin
               state_s = ST_EMPTY;
               ctrl_s  = {CTRL_W{1'b0}};
            end
         endcase
      end
   end

   // Saturating stall counter; clear beats increment.
   always_comb begin
      if (stall_clr) begin
         cnt_s = {CNT_W{1'b0}};
      end else if (out_valid && !out_ready && (cnt_r != CNT_MAX)) begin
         cnt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // State and payload registers; reset overrides flush and transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_EMPTY;
         ctrl_r  <= {CTRL_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_ctrl_r <= {CTRL_W{1'b0}};
         skid_data_r <= {DATA_W{1'b0}};
`endif
      end else begin
         state_r <= state_s;
         ctrl_r  <= ctrl_s;
         data_r  <= data_s;
         cnt_r   <= cnt_s;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_ctrl_r <= skid_ctrl_s;
         skid_data_r <= skid_data_s;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (CLEAR_DATA=1, CNT_W=4); works in both
// the skid and the single-entry build.
module tb_pipe_stage_reg;

   localparam int CW = 8;
   localparam int DW = 32;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [NW-1:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [CW+DW-1:0] sb[$];
   logic [CW+DW-1:0] pend[$];
   logic [NW-1:0]    exp_cnt = 4'd0;
   bit               exp_zero = 1'b1;
   bit               acc_last;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(NW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .stall_cnt(stall_cnt), .stall_clr(stall_clr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
      return sb.size() < 2;
`else
      return (sb.size() == 0) || out_ready;
`endif
   endfunction

   // Compare outputs with the model, advance the model across the next edge, then step one cycle.
   task automatic tick();
      bit rdy, vld;
      #1;
      vld = (sb.size() != 0);
      rdy = model_ready();
      check("out_valid", 64'(out_valid), 64'(vld));
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
      if (vld) begin
         check("payload", 64'({out_ctrl, out_data}), 64'(sb[0]));
      end else begin
         check("bubble_ctrl", 64'(out_ctrl), 64'd0);
         if (exp_zero) check("cleared_data", 64'(out_data), 64'd0);
      end
      acc_last = 1'b0;
      if (reset) begin
         sb.delete();
         exp_cnt  = 4'd0;
         exp_zero = 1'b1;
      end else begin
         if (stall_clr) exp_cnt = 4'd0;
         else if (vld && !out_ready && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
         if (flush) begin
            sb.delete();
            exp_zero = 1'b1;
         end else begin
            if (vld && out_ready) void'(sb.pop_front());
            if (in_valid && rdy) begin
               sb.push_back({in_ctrl, in_data});
               exp_zero = 1'b0;
               acc_last = 1'b1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present queued payloads upstream, holding each until it is accepted.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = (pend.size() != 0);
         if (pend.size() != 0) {in_ctrl, in_data} = pend[0];
         tick();
         if (acc_last) void'(pend.pop_front());
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [CW+DW-1:0] rnd_pl();
      return {CW'($urandom_range(1, 255)), DW'($urandom)};
   endfunction

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
      in_ctrl = 8'h00; in_data = 32'h0;
      @(posedge clk);
      @(negedge clk);
      tick();
      reset = 1'b0;
      tick();

      // First payload and a 10-deep back-to-back stream
      out_ready = 1'b1;
      pend.push_back({8'hA5, 32'hDEADBEEF});
      for (int i = 0; i < 10; i++) pend.push_back({8'(i + 1), 32'(32'h1000 + i)});
      run(11);
      check("stream_done", 64'(pend.size()), 64'd0);
      tick();
      tick();

      // Stall counting, clear and saturation
      pend.push_back({8'h3C, 32'h0BADF00D});
      out_ready = 1'b0;
      run(1);
      repeat (5) tick();
      check("stall_cnt_5", 64'(stall_cnt), 64'd5);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      check("stall_clr", 64'(stall_cnt), 64'd0);
      repeat (20) tick();
      check("stall_sat", 64'(stall_cnt), 64'hF);
      out_ready = 1'b1;
      tick();
      tick();

      // Back-pressure with three payloads offered
      out_ready = 1'b0;
      pend.push_back({8'h11, 32'hAAAA0001});
      pend.push_back({8'h22, 32'hAAAA0002});
      pend.push_back({8'h33, 32'hAAAA0003});
      run(4);
`ifdef PIPE_STAGE_REG_SKID_EN
      check("skid_full_ready", 64'(in_ready), 64'd0);
      check("skid_p3_held", 64'(pend.size()), 64'd1);
`else
      check("noskid_held", 64'(pend.size()), 64'd2);
`endif
      out_ready = 1'b1;
      run(6);
      check("bp_all_sent", 64'(pend.size()), 64'd0);
      tick();
      tick();

      // Flush with the stage full and a new payload offered
      out_ready = 1'b0;
      pend.push_back({8'h44, 32'hBBBB0001});
      pend.push_back({8'h55, 32'hBBBB0002});
      run(3);
      pend.delete();
      in_valid = 1'b1; in_ctrl = 8'h99; in_data = 32'hCAFE0099;
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ctrl", 64'(out_ctrl), 64'd0);
      check("flush_data", 64'(out_data), 64'd0);
      out_ready = 1'b1;
      repeat (3) tick();

      // Reset together with flush and an input transfer
      out_ready = 1'b0;
      pend.push_back({8'h66, 32'hCCCC0001});
      run(4);
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h77; in_data = 32'hCCCC0002;
      tick();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_cnt", 64'(stall_cnt), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      tick();

      // Full stage with simultaneous drain and refill
      out_ready = 1'b0;
      pend.push_back({8'h81, 32'hDDDD0001});
      run(2);
      out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h82; in_data = 32'hDDDD0002;
      #1;
      check("reload_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("reload_payload", 64'({out_ctrl, out_data}), 64'({8'h82, 32'hDDDD0002}));
      tick();

      // Random traffic with sporadic flush and counter clear
      for (int i = 0; i < 400; i++) begin
         if (pend.size() < 3 && $urandom_range(0, 3) != 0) pend.push_back(rnd_pl());
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         stall_clr = ($urandom_range(0, 29) == 0);
         run(1);
      end
      flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
